// File: rtl/qid_issue_sched.sv
// qid_issue_sched: issue scheduler in front of the QID decode stage.
// Pops the instruction buffer, consumes feedback barriers, tracks measurements.
module qid_issue_sched #(
  parameter int CNT_BW = 4,
  parameter int OPCODE_BW = 6,
  parameter logic [OPCODE_BW-1:0] INVALID_OPCODE = 6'd0,
  parameter logic [OPCODE_BW-1:0] LQM_X_OPCODE = 6'd4,
  parameter logic [OPCODE_BW-1:0] LQM_Y_OPCODE = 6'd5,
  parameter logic [OPCODE_BW-1:0] LQM_Z_OPCODE = 6'd6,
  parameter logic [OPCODE_BW-1:0] LQM_FB_OPCODE = 6'd7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 instbuf_empty,
  input  logic [OPCODE_BW-1:0] instbuf_opcode,
  output logic                 instbuf_rden,
  input  logic                 qifdone,
  input  logic                 reg_stall,
  input  logic                 lmu_meas_done,
  output logic [OPCODE_BW-1:0] dec_opcode,
  output logic                 all_decoded,
  output logic [CNT_BW-1:0]    outstanding,
  output logic                 busy,
  output logic                 err_underflow
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_FB    = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [OPCODE_BW-1:0] dec_nxt;
  logic                 ad_nxt;
  logic [CNT_BW-1:0]    cnt_nxt;
  logic                 err_nxt;
  logic                 head_meas;
  logic                 head_fb;
  logic                 at_max;
  logic                 pop;
  logic                 meas_pop;

  assign head_meas = (instbuf_opcode == LQM_X_OPCODE)
                   | (instbuf_opcode == LQM_Y_OPCODE)
                   | (instbuf_opcode == LQM_Z_OPCODE);
  assign head_fb   = (instbuf_opcode == LQM_FB_OPCODE);
  assign at_max    = &outstanding;

  // A return in the same cycle frees the slot, so a full counter
  // only blocks a measurement when no done arrives alongside it.
  assign pop = (state == S_ISSUE) & ~instbuf_empty & ~reg_stall
             & ~(head_meas & at_max & ~lmu_meas_done);
  assign meas_pop     = pop & head_meas;
  assign instbuf_rden = pop;
  assign busy = (state != S_IDLE) & (state != S_DONE);

  // Measurement counter: never wraps, flags a return with nothing pending.
  always_comb begin
    cnt_nxt = outstanding;
    err_nxt = err_underflow;
    unique case ({meas_pop, lmu_meas_done})
      2'b10: cnt_nxt = outstanding + 1'b1;
      2'b01: begin
        if (outstanding == '0) err_nxt = 1'b1;
        else cnt_nxt = outstanding - 1'b1;
      end
      default: ;
    endcase
  end

  // Issue FSM and decode-opcode selection.
  always_comb begin
    state_nxt = state;
    dec_nxt   = dec_opcode;
    ad_nxt    = all_decoded;
    unique case (state)
      S_IDLE: begin
        dec_nxt = INVALID_OPCODE;
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (pop) begin
          if (head_fb) begin
            dec_nxt   = INVALID_OPCODE;
            state_nxt = S_FB;
          end else begin
            dec_nxt = instbuf_opcode;
          end
        end else if (instbuf_empty & qifdone & ~reg_stall) begin
          dec_nxt   = INVALID_OPCODE;
          state_nxt = S_DRAIN;
        end else if (~reg_stall) begin
          dec_nxt = INVALID_OPCODE;
        end
      end
      S_FB: begin
        if (~reg_stall) dec_nxt = INVALID_OPCODE;
        if (outstanding == '0) state_nxt = S_ISSUE;
      end
      S_DRAIN: begin
        dec_nxt = INVALID_OPCODE;
        if (~reg_stall) begin
          ad_nxt    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: ;
      default: begin
        dec_nxt   = INVALID_OPCODE;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State registers; reset forgets in-flight measurements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      dec_opcode    <= INVALID_OPCODE;
      all_decoded   <= 1'b0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      dec_opcode    <= dec_nxt;
      all_decoded   <= ad_nxt;
      outstanding   <= cnt_nxt;
      err_underflow <= err_nxt;
    end
  end

endmodule

// File: tb/tb_qid_issue_sched.sv
// tb_qid_issue_sched: directed vectors for the QID issue scheduler.
// Buffer is modelled as a simple FIFO popped by instbuf_rden.
module tb_qid_issue_sched;

  localparam logic [5:0] OP_INV   = 6'd0;
  localparam logic [5:0] OP_LQI   = 6'd1;
  localparam logic [5:0] OP_MERGE = 6'd2;
  localparam logic [5:0] OP_PPM   = 6'd3;
  localparam logic [5:0] OP_X     = 6'd4;
  localparam logic [5:0] OP_Y     = 6'd5;
  localparam logic [5:0] OP_Z     = 6'd6;
  localparam logic [5:0] OP_FB    = 6'd7;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       instbuf_empty;
  logic [5:0] instbuf_opcode;
  logic       instbuf_rden;
  logic       qifdone;
  logic       reg_stall;
  logic       lmu_meas_done;
  logic [5:0] dec_opcode;
  logic       all_decoded;
  logic [1:0] outstanding;
  logic       busy;
  logic       err_underflow;

  qid_issue_sched #(
    .CNT_BW(2),
    .OPCODE_BW(6),
    .INVALID_OPCODE(OP_INV),
    .LQM_X_OPCODE(OP_X),
    .LQM_Y_OPCODE(OP_Y),
    .LQM_Z_OPCODE(OP_Z),
    .LQM_FB_OPCODE(OP_FB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .instbuf_empty(instbuf_empty),
    .instbuf_opcode(instbuf_opcode),
    .instbuf_rden(instbuf_rden),
    .qifdone(qifdone),
    .reg_stall(reg_stall),
    .lmu_meas_done(lmu_meas_done),
    .dec_opcode(dec_opcode),
    .all_decoded(all_decoded),
    .outstanding(outstanding),
    .busy(busy),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  bmem [64];
  int unsigned bhead = 0;
  int unsigned btail = 0;

  assign instbuf_empty  = (bhead == btail);
  assign instbuf_opcode = bmem[bhead[5:0]];

  always @(posedge clk)
    if (instbuf_rden && !instbuf_empty) bhead <= bhead + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic push(input logic [5:0] op);
    bmem[btail[5:0]] = op;
    btail = btail + 1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic s, input logic st,
                       input logic d, input logic q);
    start         = s;
    reg_stall     = st;
    lmu_meas_done = d;
    qifdone       = q;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            rst;
    int              nld;
    logic [2:0][5:0] ld;
    logic            start, stall, done, qif;
    logic            rden;
    logic [5:0]      dec;
    logic [1:0]      cnt;
    logic            ad, busy;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input int nld,
    input logic [5:0] l0, input logic [5:0] l1, input logic [5:0] l2,
    input logic s, input logic st, input logic d, input logic q,
    input logic rd, input logic [5:0] dc, input logic [1:0] c,
    input logic ad, input logic b);
    vec_t v;
    v.rst = rst; v.nld = nld;
    v.ld[0] = l0; v.ld[1] = l1; v.ld[2] = l2;
    v.start = s; v.stall = st; v.done = d; v.qif = q;
    v.rden = rd; v.dec = dc; v.cnt = c; v.ad = ad; v.busy = b;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    reg_stall = 1'b0;
    lmu_meas_done = 1'b0;
    qifdone = 1'b0;

    // straight-line program, then start ignored in DONE
    tbl[0]  = mk(1, 3, OP_LQI, OP_MERGE, OP_PPM,
                 1, 0, 0, 1, 0, OP_INV, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, OP_INV, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, OP_LQI, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, OP_MERGE, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OP_PPM, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OP_INV, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OP_INV, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, OP_INV, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OP_INV, 0, 1, 0);
    // stall hold on a measurement
    tbl[9]  = mk(1, 2, OP_X, OP_LQI, 0,
                 1, 0, 0, 0, 0, OP_INV, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, OP_INV, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, OP_X, 1, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, OP_X, 1, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, OP_X, 1, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, OP_X, 1, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OP_LQI, 1, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, OP_INV, 1, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OP_INV, 0, 0, 1);

    adv();
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rst) do_reset();
      for (int j = 0; j < tbl[i].nld; j++) push(tbl[i].ld[j]);
      drive(tbl[i].start, tbl[i].stall, tbl[i].done, tbl[i].qif);
      chk($sformatf("v%0d rden", i), 8'(instbuf_rden), 8'(tbl[i].rden));
      chk($sformatf("v%0d dec", i), 8'(dec_opcode), 8'(tbl[i].dec));
      chk($sformatf("v%0d cnt", i), 8'(outstanding), 8'(tbl[i].cnt));
      chk($sformatf("v%0d ad", i), 8'(all_decoded), 8'(tbl[i].ad));
      chk($sformatf("v%0d busy", i), 8'(busy), 8'(tbl[i].busy));
      adv();
    end

    // feedback barrier: LQI waits for both measurements to return
    do_reset();
    push(OP_Z); push(OP_X); push(OP_FB); push(OP_LQI);
    for (int c = 0; c < 14; c++) begin
      logic       e_rd;
      logic [1:0] e_cnt;
      logic [5:0] e_dec;
      drive(c == 0, 1'b0, (c == 5) || (c == 10), 1'b0);
      e_rd  = (c >= 1 && c <= 3) || (c == 12);
      e_cnt = (c <= 1) ? 2'd0 : (c == 2) ? 2'd1 : (c <= 5) ? 2'd2 :
              (c <= 10) ? 2'd1 : 2'd0;
      e_dec = (c == 2) ? OP_Z : (c == 3) ? OP_X :
              (c == 13) ? OP_LQI : OP_INV;
      chk($sformatf("fb c%0d rden", c), 8'(instbuf_rden), 8'(e_rd));
      chk($sformatf("fb c%0d cnt", c), 8'(outstanding), 8'(e_cnt));
      chk($sformatf("fb c%0d dec", c), 8'(dec_opcode), 8'(e_dec));
      adv();
    end

    // counter saturation at 3 with four queued measurements
    do_reset();
    for (int k = 0; k < 4; k++) push(OP_Y);
    for (int c = 0; c < 10; c++) begin
      logic       e_rd;
      logic [1:0] e_cnt;
      logic [5:0] e_dec;
      drive(c == 0, 1'b0, (c == 6) || (c == 8), 1'b0);
      e_rd  = (c >= 1 && c <= 3) || (c == 6);
      e_cnt = (c <= 1) ? 2'd0 : (c == 2) ? 2'd1 : (c == 3) ? 2'd2 :
              (c <= 8) ? 2'd3 : 2'd2;
      e_dec = (c >= 2 && c <= 4) || (c == 7) ? OP_Y : OP_INV;
      chk($sformatf("sat c%0d rden", c), 8'(instbuf_rden), 8'(e_rd));
      chk($sformatf("sat c%0d cnt", c), 8'(outstanding), 8'(e_cnt));
      chk($sformatf("sat c%0d dec", c), 8'(dec_opcode), 8'(e_dec));
      chk($sformatf("sat c%0d err", c), 8'(err_underflow), 8'd0);
      adv();
    end

    // underflow: sticky error, counter pinned at zero
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("uf pre err", 8'(err_underflow), 8'd0);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("uf err", 8'(err_underflow), 8'd1);
    chk("uf cnt", 8'(outstanding), 8'd0);
    adv();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("uf sticky", 8'(err_underflow), 8'd1);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("uf sticky2", 8'(err_underflow), 8'd1);
    chk("uf cnt2", 8'(outstanding), 8'd0);
    adv();

    // async reset while waiting on a barrier with two pending
    do_reset();
    push(OP_Z); push(OP_X); push(OP_FB);
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 1'b0, 1'b0, 1'b0);
      if (c < 4) adv();
    end
    chk("ar pre cnt", 8'(outstanding), 8'd2);
    chk("ar pre busy", 8'(busy), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar rden", 8'(instbuf_rden), 8'd0);
    chk("ar dec", 8'(dec_opcode), 8'(OP_INV));
    chk("ar cnt", 8'(outstanding), 8'd0);
    chk("ar ad", 8'(all_decoded), 8'd0);
    chk("ar busy", 8'(busy), 8'd0);
    chk("ar err", 8'(err_underflow), 8'd0);
    rst_n = 1'b1;
    adv();
    push(OP_LQI);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ar start rden", 8'(instbuf_rden), 8'd0);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ar first rden", 8'(instbuf_rden), 8'd1);
    adv();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ar first dec", 8'(dec_opcode), 8'(OP_LQI));
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
